triangle_scheduler: RTL and testbench
=====================================

Name: triangle_scheduler

Overview:
Front-end controller for the triangle_filler datapath. Accepts triangle draw commands from NUM_REQ requesters over valid/ready handshakes and arbitrates between them round-robin. Accepted commands are buffered in a small FIFO. Each command is issued to the filler as a one-cycle start pulse with stable vertex coordinates, and the scheduler waits for the filler's done before issuing the next. Sits between the command sources (CPU bridge, display-list reader) and the single shared triangle_filler.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 65535, max cycles waited for done before a command is aborted (<2^16)

Ports:
clk  input  1  system clock; all state rising-edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester command valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_coords  input  54*NUM_REQ  per-requester command; slice i = bits [54i+53:54i]; within slice: [8:0]x1 [17:9]y1 [26:18]x2 [35:27]y2 [44:36]x3 [53:45]y3
fill_x1, fill_y1, fill_x2, fill_y2, fill_x3, fill_y3  output  9 each  coordinates to triangle_filler
fill_start  output  1  one-cycle start pulse to triangle_filler
fill_done  input  1  triangle_filler done (level; rising edge = completion)
busy  output  1  FIFO non-empty or state != IDLE
queue_level  output  clog2(DEPTH+1)  current FIFO occupancy
tri_count  output  16  triangles completed (wraps 65535->0)
timeout_err  output  1  sticky; set on any aborted command

Behaviour:
- Reset (reset=0, async): state IDLE; FIFO empty; RR pointer=0; all outputs 0, including fill_* coords and timeout_err; done_q=0.
- Arbitration: combinational. If queue_level<DEPTH, grant goes to the first requester with valid high, scanning from the RR pointer upward with wrap. req_ready is one-hot on the grant, else all zero. Ready does not depend on a same-cycle pop (no full-bypass).
- Transfer happens when req_valid[i]&req_ready[i]. The slice is pushed and the RR pointer becomes (i+1) mod NUM_REQ. The pointer is unchanged when no transfer occurs.
- FIFO: push and pop in the same cycle are allowed (when not full / not empty); queue_level is unchanged. Order is strictly preserved.
- done_q registers fill_done each cycle; done_rise = fill_done & ~done_q.
- FSM:
  IDLE: if FIFO non-empty → pop the head into fill_* registers → LAUNCH.
  LAUNCH: fill_start=1 for exactly this cycle; clear the wait counter → WAIT. A done_rise in this cycle counts as completion → IDLE.
  WAIT: on done_rise → tri_count+1 → IDLE. Otherwise the counter increments. On counter==TIMEOUT → timeout_err=1, no tri_count increment → IDLE.
- fill_* coords change only on a pop. They are stable from LAUNCH through the end of WAIT.
- A done already high on entering WAIT (no rising edge) is not a completion.
- Latency: command accepted at edge N into an empty FIFO with IDLE state: pop at edge N+1; fill_start high in cycle N+1..N+2.
- Back-to-back: completion edge M → IDLE → pop at M+1 → start in cycle after M+1. Minimum 3 cycles start-to-start plus filler time.
- Reset mid-WAIT: the command is discarded; the filler is not notified (it is reset by the same reset).
- busy is combinational from state and queue_level.

Test Plan:
- Single command: req0 (x1=5,y1=4,x2=12,y2=8,x3=8,y3=10) valid 1 cycle → accepted at that edge; fill_start high exactly 1 cycle, one edge after the pop; fill_x1=5…fill_y3=10 stable until done; done rise → tri_count=1, busy=0.
- Round-robin: req0 and req1 held valid continuously with distinct coords, filler model done 20 cycles after start → grants alternate 0,1,0,1; fill_x1 sequence matches; after 6 completions tri_count=6.
- Full FIFO: DEPTH=4, filler never completes; push 5 commands from req0 → first popped, 4 queued, queue_level=4, req_ready=0; 6th held until a pop.
- Timeout: TIMEOUT=100, done never asserted → fill_start once, IDLE after 100 WAIT cycles, timeout_err=1, tri_count=0; next queued command launches.
- Stale done: fill_done held high before start → no completion until done falls and rises again; tri_count increments once.
- Async reset while in WAIT with 2 queued → immediately queue_level=0, fill_start=0, busy=0, coords 0; no start after reset release.

Source files
------------

// File: rtl/triangle_scheduler.sv
// Purpose: round-robin arbiter, command FIFO and launch/wait sequencer feeding one triangle_filler.
// Latency: a command accepted into an empty FIFO while idle is popped on the next edge; fill_start follows one cycle later.
// Backpressure: req_ready drops for all requesters while the FIFO is full; a pop in the same cycle does not reopen it.
//
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake; req_ready is one-hot on the grant
//   req_coords                  54 bits per requester: {y3,x3,y2,x2,y1,x1}, 9 bits each
//   fill_x1..fill_y3            coordinates to the filler, held from LAUNCH through WAIT
//   fill_start                  one-cycle start pulse to the filler
//   fill_done                   filler done level; its rising edge marks completion
//   busy                        FIFO non-empty or a command is in flight
//   queue_level                 FIFO occupancy
//   tri_count                   completed triangles, wraps at 16 bits
//   timeout_err                 sticky flag, set when a command is abandoned after TIMEOUT wait cycles
module triangle_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [54*NUM_REQ-1:0]      req_coords,
    output logic [8:0]                 fill_x1,
    output logic [8:0]                 fill_y1,
    output logic [8:0]                 fill_x2,
    output logic [8:0]                 fill_y2,
    output logic [8:0]                 fill_x3,
    output logic [8:0]                 fill_y3,
    output logic                       fill_start,
    input  logic                       fill_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] queue_level,
    output logic [15:0]                tri_count,
    output logic                       timeout_err
);

    localparam int QW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // wait_cnt holds the number of WAIT cycles already spent, so the
    // abort fires in the TIMEOUT-th WAIT cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rr_ptr;
    logic [RW-1:0] grant_idx;
    logic [RW-1:0] cand;
    logic          grant_vld;
    logic          push;
    logic          pop;
    logic [53:0]   push_dat;
    logic [53:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          done_q;
    logic          done_rise;
    logic [15:0]   wait_cnt;
    logic          complete;
    logic          abort;
    logic          cnt_clr;
    logic          cnt_inc;

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (queue_level < QW'(DEPTH)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = RW'((32'(rr_ptr) + k) % NUM_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    // Ready is only raised for a valid requester, so a grant is a transfer.
    assign push      = grant_vld;
    assign push_dat  = req_coords[grant_idx*54 +: 54];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Command FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   queue_level <= queue_level + QW'(1);
                2'b01:   queue_level <= queue_level - QW'(1);
                default: queue_level <= queue_level;
            endcase
        end
    end

    assign done_rise = fill_done & ~done_q;
    assign busy      = (state != S_IDLE) || (queue_level != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        fill_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (queue_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                fill_start = 1'b1;
                // A filler that finishes within the start cycle still counts.
                if (done_rise) begin
                    complete  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_rise) begin
                    complete  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_inc   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q      <= 1'b0;
            wait_cnt    <= '0;
            tri_count   <= '0;
            timeout_err <= 1'b0;
            fill_x1     <= '0;
            fill_y1     <= '0;
            fill_x2     <= '0;
            fill_y2     <= '0;
            fill_x3     <= '0;
            fill_y3     <= '0;
        end else begin
            done_q <= fill_done;
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (complete) tri_count   <= tri_count + 16'd1;
            if (abort)    timeout_err <= 1'b1;
            // Coordinates only move on a pop, so they stay stable for the filler.
            if (pop) begin
                {fill_y3, fill_x3, fill_y2, fill_x2, fill_y1, fill_x1} <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_triangle_scheduler.sv
// Purpose: randomized and directed bench for triangle_scheduler against a timing-level reference model.
// Latency: checks every cycle on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: requesters hold valid and data until the model grants them.
module tb_triangle_scheduler;

    localparam int NUM_REQ = 3;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 100;
    localparam int QW      = $clog2(DEPTH + 1);

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [54*NUM_REQ-1:0] req_coords;
    logic [8:0]            fill_x1, fill_y1, fill_x2, fill_y2, fill_x3, fill_y3;
    logic                  fill_start;
    logic                  fill_done;
    logic                  busy;
    logic [QW-1:0]         queue_level;
    logic [15:0]           tri_count;
    logic                  timeout_err;

    always #5 clk = ~clk;

    triangle_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_coords  (req_coords),
        .fill_x1     (fill_x1),
        .fill_y1     (fill_y1),
        .fill_x2     (fill_x2),
        .fill_y2     (fill_y2),
        .fill_x3     (fill_x3),
        .fill_y3     (fill_y3),
        .fill_start  (fill_start),
        .fill_done   (fill_done),
        .busy        (busy),
        .queue_level (queue_level),
        .tri_count   (tri_count),
        .timeout_err (timeout_err)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: commands as a queue, the in-flight command described
    // by the cycle it launched in, completion by done edges or elapsed time.
    logic [53:0] m_q[$];
    int          m_rr;
    bit          m_inflight;
    int          m_launch;
    logic [53:0] m_coords;
    bit          m_prev_done;
    int          m_tri;
    bit          m_terr;
    int          m_t;
    int          m_last_grant;

    // Stimulus state.
    logic [53:0]        rq_cmd [NUM_REQ];
    bit                 rq_pend [NUM_REQ];
    int                 req_mode;   // 0 no new commands, 1 random, 2 always
    logic [NUM_REQ-1:0] req_mask;
    int                 gen_budget; // commands still to generate, -1 unlimited
    int                 done_mode;  // 0 low, 1 high, 2 filler model, 3 random toggle
    int                 auto_dly;   // 0 means random 1..20
    int                 done_at;
    int                 tri_base;

    function automatic int model_grant();
        int idx;
        if (m_q.size() >= DEPTH) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_rr + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_rr         = 0;
        m_inflight   = 1'b0;
        m_coords     = '0;
        m_prev_done  = 1'b0;
        m_tri        = 0;
        m_terr       = 1'b0;
        m_last_grant = -1;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]            = rq_pend[i];
            req_coords[i*54 +: 54]  = rq_cmd[i];
        end
    endtask

    task automatic drive_cycle();
        logic [63:0] r;
        if (m_last_grant >= 0) rq_pend[m_last_grant] = 1'b0;
        m_last_grant = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_mask[i] && !rq_pend[i] && gen_budget != 0 &&
                (req_mode == 2 || (req_mode == 1 && $urandom_range(0, 2) == 0))) begin
                r          = {$urandom(), $urandom()};
                rq_cmd[i]  = r[53:0];
                rq_pend[i] = 1'b1;
                if (gen_budget > 0) gen_budget--;
            end
        end
        case (done_mode)
            0:       fill_done = 1'b0;
            1:       fill_done = 1'b1;
            2:       fill_done = (done_at >= 0) && (m_t >= done_at) && (m_t < done_at + 2);
            default: if ($urandom_range(0, 5) == 0) fill_done = ~fill_done;
        endcase
        apply_inputs();
    endtask

    task automatic check_and_step();
        int                 g;
        bit                 rise;
        logic [NUM_REQ-1:0] exp_rdy;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("ready", req_ready, exp_rdy);
        check_val("level", queue_level, m_q.size());
        check_val("start", fill_start, m_inflight && (m_t == m_launch));
        check_val("busy", busy, m_inflight || (m_q.size() != 0));
        check_val("coords", {fill_y3, fill_x3, fill_y2, fill_x2, fill_y1, fill_x1}, m_coords);
        check_val("tri", tri_count, 16'(m_tri));
        check_val("terr", timeout_err, m_terr);
        // Filler model reacts to the pulse it actually receives.
        if (done_mode == 2 && fill_start === 1'b1)
            done_at = m_t + ((auto_dly > 0) ? auto_dly : $urandom_range(1, 20));
        rise        = fill_done && !m_prev_done;
        m_prev_done = fill_done;
        if (m_inflight) begin
            if (rise) begin
                m_tri++;
                m_inflight = 1'b0;
            end else if (m_t == m_launch + TIMEOUT) begin
                m_terr     = 1'b1;
                m_inflight = 1'b0;
            end
        end else if (m_q.size() > 0) begin
            m_coords   = m_q.pop_front();
            m_inflight = 1'b1;
            m_launch   = m_t + 1;
        end
        if (g >= 0) begin
            m_q.push_back(rq_cmd[g]);
            m_rr = (g + 1) % NUM_REQ;
        end
        m_last_grant = g;
        m_t++;
    endtask

    task automatic one_cycle();
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
        drive_cycle();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) one_cycle();
    endtask

    task automatic run_until_tri(input int target, input int budget);
        int b;
        b = 0;
        while (m_tri < target && b < budget) begin
            one_cycle();
            b++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [53:0] c;
        model_reset();
        m_t        = 0;
        req_mode   = 0;
        req_mask   = '0;
        gen_budget = -1;
        done_mode  = 0;
        auto_dly   = 0;
        done_at    = -1;
        fill_done  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_cmd[i]  = '0;
            rq_pend[i] = 1'b0;
        end
        apply_inputs();

        // Reset state.
        #1 reset = 1'b0;
        #2;
        check_val("rst_level", queue_level, 0);
        check_val("rst_start", fill_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_coords", {fill_y3, fill_x3, fill_y2, fill_x2, fill_y1, fill_x1}, 0);
        check_val("rst_tri", tri_count, 0);
        check_val("rst_terr", timeout_err, 0);
        check_val("rst_ready", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single command from requester 0.
        done_mode  = 2;
        auto_dly   = 6;
        c          = {9'd10, 9'd8, 9'd8, 9'd12, 9'd4, 9'd5};
        rq_cmd[0]  = c;
        rq_pend[0] = 1'b1;
        apply_inputs();
        run_cycles(15);
        check_val("single_tri", tri_count, 1);
        check_val("single_busy", busy, 0);
        check_val("single_x1", fill_x1, 5);
        check_val("single_y3", fill_y3, 10);

        // Round robin between requesters 0 and 1, filler takes 20 cycles.
        req_mode = 2;
        req_mask = 3'b011;
        auto_dly = 20;
        drive_cycle();
        run_until_tri(7, 400);
        check_val("rr_tri", tri_count, 7);
        req_mode = 0;
        auto_dly = 0;
        drive_cycle();
        run_cycles(300);
        check_val("rr_drain_level", queue_level, 0);
        check_val("rr_drain_busy", busy, 0);

        // Full FIFO with a filler that never finishes, then timeout.
        tri_base   = m_tri;
        done_mode  = 0;
        req_mode   = 2;
        req_mask   = 3'b001;
        gen_budget = 6;
        drive_cycle();
        run_cycles(10);
        check_val("full_level", queue_level, 4);
        check_val("full_ready", req_ready, 0);
        check_val("full_terr", timeout_err, 0);
        run_cycles(115);
        check_val("to_err", timeout_err, 1);
        check_val("to_tri", tri_count, 16'(tri_base));
        check_val("to_level", queue_level, 4);
        req_mode   = 0;
        gen_budget = -1;
        done_mode  = 2;
        done_at    = -1;
        drive_cycle();
        run_cycles(400);
        check_val("full_drain_level", queue_level, 0);
        check_val("full_drain_busy", busy, 0);

        // Stale done: level already high when the command launches.
        done_mode = 1;
        drive_cycle();
        run_cycles(3);
        tri_base   = m_tri;
        c          = 54'h2A_5555_1234_ABC;
        rq_cmd[0]  = c;
        rq_pend[0] = 1'b1;
        apply_inputs();
        run_cycles(30);
        check_val("stale_tri", tri_count, 16'(tri_base));
        check_val("stale_busy", busy, 1);
        done_mode = 0;
        drive_cycle();
        run_cycles(3);
        done_mode = 1;
        drive_cycle();
        run_cycles(5);
        check_val("stale_done_tri", tri_count, 16'(tri_base + 1));
        check_val("stale_idle", busy, 0);

        // Random traffic from all requesters with a randomly toggling done.
        req_mode   = 1;
        req_mask   = 3'b111;
        gen_budget = -1;
        done_mode  = 3;
        drive_cycle();
        run_cycles(1500);
        req_mode  = 0;
        done_mode = 2;
        done_at   = -1;
        drive_cycle();
        run_cycles(400);
        check_val("rand_drain_level", queue_level, 0);
        check_val("rand_drain_busy", busy, 0);

        // Asynchronous reset while waiting with two commands queued.
        done_mode  = 0;
        req_mode   = 2;
        req_mask   = 3'b001;
        gen_budget = 3;
        drive_cycle();
        run_cycles(10);
        check_val("pre_rst_level", queue_level, 2);
        check_val("pre_rst_busy", busy, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("arst_level", queue_level, 0);
        check_val("arst_start", fill_start, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_coords", {fill_y3, fill_x3, fill_y2, fill_x2, fill_y1, fill_x1}, 0);
        check_val("arst_tri", tri_count, 0);
        check_val("arst_terr", timeout_err, 0);
        model_reset();
        req_mode   = 0;
        gen_budget = 0;
        done_at    = -1;
        fill_done  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rq_pend[i] = 1'b0;
        apply_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_cycles(20);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_tri", tri_count, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
